wb_arbiter: RTL and testbench



---
 rtl/wb_arbiter_pkg.sv | 18 +
 rtl/wb_load_queue.sv | 71 +++++++
 rtl/wb_arbiter.sv | 103 ++++++++++
 tb/tb_wb_arbiter.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/wb_arbiter_pkg.sv
// Shared types and constants for the write-back arbiter and its load queue.
// The queue entry carries DATA_W bits of load data; instantiate with XLEN == DATA_W.
package wb_arbiter_pkg;

  localparam int REG_IDX_W = 5;
  localparam int DATA_W    = 32;

  localparam logic [REG_IDX_W-1:0] X0_IDX = 5'd0;

  typedef struct packed {
    logic [REG_IDX_W-1:0] rd;
    logic [DATA_W-1:0]    data;
    logic                 filled;
  } lq_entry_t;

  localparam lq_entry_t LQ_ENTRY_RST = '{rd: 5'd0, data: 32'd0, filled: 1'b0};

endpackage

// File: rtl/wb_load_queue.sv
// In-order circular buffer of outstanding loads: entries are pushed at the tail,
// filled in order by memory responses and popped at the head once filled.
module wb_load_queue
  import wb_arbiter_pkg::*;
#(
  parameter int XLEN   = DATA_W,
  parameter int QDEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [REG_IDX_W-1:0]   push_rd,
  input  logic                   fill,
  input  logic [XLEN-1:0]        fill_data,
  input  logic                   pop,
  output logic                   head_filled,
  output logic [REG_IDX_W-1:0]   head_rd,
  output logic [XLEN-1:0]        head_data,
  output logic                   full,
  output logic                   has_unfilled,
  output logic [$clog2(QDEPTH):0] count
);

  localparam int PTR_W = $clog2(QDEPTH);
  localparam int CNT_W = PTR_W + 1;

  lq_entry_t        mem_r [QDEPTH];
  logic [PTR_W-1:0] tail_r;
  logic [PTR_W-1:0] fill_r;
  logic [PTR_W-1:0] head_r;
  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] unfilled_r;

  // Unfilled entries are tracked separately because fill_r == tail_r is ambiguous when full.
  assign full         = (count_r == CNT_W'(QDEPTH));
  assign has_unfilled = (unfilled_r != {CNT_W{1'b0}});
  assign head_filled  = (count_r != {CNT_W{1'b0}}) && mem_r[head_r].filled;
  assign head_rd      = mem_r[head_r].rd;
  assign head_data    = mem_r[head_r].data;
  assign count        = count_r;

  // Pointer, counter and entry storage updates; callers guarantee push/fill/pop legality.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < QDEPTH; i++) begin
        mem_r[i] <= LQ_ENTRY_RST;
      end
      tail_r     <= {PTR_W{1'b0}};
      fill_r     <= {PTR_W{1'b0}};
      head_r     <= {PTR_W{1'b0}};
      count_r    <= {CNT_W{1'b0}};
      unfilled_r <= {CNT_W{1'b0}};
    end else begin
      if (push) begin
        mem_r[tail_r] <= '{rd: push_rd, data: {DATA_W{1'b0}}, filled: 1'b0};
        tail_r        <= tail_r + PTR_W'(1);
      end
      if (fill) begin
        mem_r[fill_r].data   <= fill_data;
        mem_r[fill_r].filled <= 1'b1;
        fill_r               <= fill_r + PTR_W'(1);
      end
      if (pop) begin
        head_r <= head_r + PTR_W'(1);
      end
      count_r    <= count_r + CNT_W'(push) - CNT_W'(pop);
      unfilled_r <= unfilled_r + CNT_W'(push) - CNT_W'(fill);
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter: ALU results take the register-file write port first,
// filled loads drain in order otherwise; a busy scoreboard drives the decode hazard.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int XLEN   = DATA_W,
  parameter int QDEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    alu_valid,
  input  logic [REG_IDX_W-1:0]    alu_rd,
  input  logic [XLEN-1:0]         alu_data,
  input  logic                    ld_issue_valid,
  input  logic [REG_IDX_W-1:0]    ld_issue_rd,
  output logic                    ld_issue_ready,
  input  logic                    mem_resp_valid,
  input  logic [XLEN-1:0]         mem_resp_data,
  input  logic [REG_IDX_W-1:0]    dec_rs1,
  input  logic [REG_IDX_W-1:0]    dec_rs2,
  input  logic [REG_IDX_W-1:0]    dec_rd,
  output logic                    hazard,
  output logic [REG_IDX_W-1:0]    rdi,
  output logic [XLEN-1:0]         write_data,
  output logic                    reg_write,
  output logic [$clog2(QDEPTH):0] pending,
  output logic                    resp_err
);

  localparam int NREGS = 1 << REG_IDX_W;

  logic                 issue_s;
  logic                 fill_s;
  logic                 pop_s;
  logic                 head_filled_s;
  logic [REG_IDX_W-1:0] head_rd_s;
  logic [XLEN-1:0]      head_data_s;
  logic                 full_s;
  logic                 has_unfilled_s;
  logic [NREGS-1:0]     busy_r;
  logic [NREGS-1:0]     busy_next_s;

  assign ld_issue_ready = !full_s;
  assign issue_s        = ld_issue_valid && !full_s;
  assign fill_s         = mem_resp_valid && has_unfilled_s;
  assign pop_s          = !alu_valid && head_filled_s;
  assign hazard         = busy_r[dec_rs1] | busy_r[dec_rs2] | busy_r[dec_rd];

  wb_load_queue #(.XLEN(XLEN), .QDEPTH(QDEPTH)) u_queue (
    .clk          (clk),
    .rst          (rst),
    .push         (issue_s),
    .push_rd      (ld_issue_rd),
    .fill         (fill_s),
    .fill_data    (mem_resp_data),
    .pop          (pop_s),
    .head_filled  (head_filled_s),
    .head_rd      (head_rd_s),
    .head_data    (head_data_s),
    .full         (full_s),
    .has_unfilled (has_unfilled_s),
    .count        (pending)
  );

  // Next scoreboard: issue sets, pop clears, x0 never tracked.
  always_comb begin
    busy_next_s = busy_r;
    for (int i = 0; i < NREGS; i++) begin
      busy_next_s[i] = (i == int'(X0_IDX))                          ? 1'b0 :
                       (issue_s && (ld_issue_rd == REG_IDX_W'(i)))  ? 1'b1 :
                       (pop_s && (head_rd_s == REG_IDX_W'(i)))      ? 1'b0 :
                                                                      busy_r[i];
    end
  end

  // Scoreboard, sticky error and registered write-port selection.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_r     <= {NREGS{1'b0}};
      resp_err   <= 1'b0;
      rdi        <= X0_IDX;
      write_data <= {XLEN{1'b0}};
      reg_write  <= 1'b0;
    end else begin
      busy_r <= busy_next_s;
      if (mem_resp_valid && !has_unfilled_s) begin
        resp_err <= 1'b1;
      end
      if (alu_valid) begin
        rdi        <= alu_rd;
        write_data <= alu_data;
        reg_write  <= (alu_rd != X0_IDX);
      end else if (pop_s) begin
        rdi        <= head_rd_s;
        write_data <= head_data_s;
        reg_write  <= (head_rd_s != X0_IDX);
      end else begin
        reg_write  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed and random stimulus for wb_arbiter, checked against a queue-based
// reference model of outstanding loads.
module tb_wb_arbiter;

  localparam int XLEN   = 32;
  localparam int QDEPTH = 4;
  localparam int PW     = $clog2(QDEPTH) + 1;

  logic            clk = 1'b0;
  logic            rst;
  logic            alu_valid;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            ld_issue_valid;
  logic [4:0]      ld_issue_rd;
  logic            ld_issue_ready;
  logic            mem_resp_valid;
  logic [XLEN-1:0] mem_resp_data;
  logic [4:0]      dec_rs1, dec_rs2, dec_rd;
  logic            hazard;
  logic [4:0]      rdi;
  logic [XLEN-1:0] write_data;
  logic            reg_write;
  logic [PW-1:0]   pending;
  logic            resp_err;

  always #5 clk = ~clk;

  wb_arbiter #(.XLEN(XLEN), .QDEPTH(QDEPTH)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_issue_valid(ld_issue_valid), .ld_issue_rd(ld_issue_rd), .ld_issue_ready(ld_issue_ready),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd),
    .hazard(hazard), .rdi(rdi), .write_data(write_data), .reg_write(reg_write),
    .pending(pending), .resp_err(resp_err)
  );

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    bit          filled;
  } ment_t;

  ment_t       mq[$];
  bit          m_err;
  bit          m_rw;
  logic [4:0]  m_rdi;
  logic [31:0] m_wd;
  int          n_assert = 0;
  int          n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // A register is busy while any outstanding load targets it.
  function automatic bit m_busy(input logic [4:0] r);
    if (r == 5'd0) return 1'b0;
    foreach (mq[i]) if (mq[i].rd == r) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_has_unfilled();
    foreach (mq[i]) if (!mq[i].filled) return 1'b1;
    return 1'b0;
  endfunction

  // One clock: drive inputs, check combinational outputs, advance model, check registered outputs.
  task automatic cyc(input bit a_v, input logic [4:0] a_rd, input logic [31:0] a_d,
                     input bit i_v, input logic [4:0] i_rd,
                     input bit r_v, input logic [31:0] r_d,
                     input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                     input bit r_in);
    bit do_pop;
    bit can_issue;
    int fi;
    alu_valid = a_v; alu_rd = a_rd; alu_data = a_d;
    ld_issue_valid = i_v; ld_issue_rd = i_rd;
    mem_resp_valid = r_v; mem_resp_data = r_d;
    dec_rs1 = rs1; dec_rs2 = rs2; dec_rd = rd; rst = r_in;
    #1;
    check("hazard", 64'(hazard), 64'(m_busy(rs1) | m_busy(rs2) | m_busy(rd)));
    check("ld_issue_ready", 64'(ld_issue_ready), 64'(mq.size() < QDEPTH));
    if (r_in) begin
      mq.delete();
      m_err = 1'b0; m_rw = 1'b0; m_rdi = 5'd0; m_wd = 32'd0;
    end else begin
      do_pop    = !a_v && (mq.size() > 0) && mq[0].filled;
      can_issue = (mq.size() < QDEPTH);
      fi = -1;
      foreach (mq[i]) if (!mq[i].filled && fi < 0) fi = i;
      if (r_v) begin
        if (fi >= 0) begin
          mq[fi].filled = 1'b1;
          mq[fi].data   = r_d;
        end else begin
          m_err = 1'b1;
        end
      end
      if (a_v) begin
        m_rw = (a_rd != 5'd0); m_rdi = a_rd; m_wd = a_d;
      end else if (do_pop) begin
        m_rw = (mq[0].rd != 5'd0); m_rdi = mq[0].rd; m_wd = mq[0].data;
        void'(mq.pop_front());
      end else begin
        m_rw = 1'b0;
      end
      if (i_v && can_issue) mq.push_back('{rd: i_rd, data: 32'd0, filled: 1'b0});
    end
    @(posedge clk);
    #1;
    check("reg_write", 64'(reg_write), 64'(m_rw));
    check("pending", 64'(pending), 64'(mq.size()));
    check("resp_err", 64'(resp_err), 64'(m_err));
    if (m_rw) begin
      check("rdi", 64'(rdi), 64'(m_rdi));
      check("write_data", 64'(write_data), 64'(m_wd));
    end
  endtask

  task automatic idle(input logic [4:0] rs1);
    cyc(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 32'd0, rs1, 5'd0, 5'd0, 1'b0);
  endtask

  initial begin
    logic [4:0]  rrd;
    bit          a_v, i_v, r_v;
    rst = 1'b1;
    alu_valid = 1'b0; alu_rd = 5'd0; alu_data = 32'd0;
    ld_issue_valid = 1'b0; ld_issue_rd = 5'd0;
    mem_resp_valid = 1'b0; mem_resp_data = 32'd0;
    dec_rs1 = 5'd0; dec_rs2 = 5'd0; dec_rd = 5'd0;
    m_err = 1'b0; m_rw = 1'b0; m_rdi = 5'd0; m_wd = 32'd0;

    // Reset state
    cyc(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 32'd0, 5'd0, 5'd0, 5'd0, 1'b1);
    cyc(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 32'd0, 5'd0, 5'd0, 5'd0, 1'b1);
    check("rst_rdi", 64'(rdi), 64'd0);
    check("rst_write_data", 64'(write_data), 64'd0);

    // ALU single write
    cyc(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 1'b0, 32'd0, 5'd0, 5'd0, 5'd0, 1'b0);
    check("t1_rdi", 64'(rdi), 64'd5);
    check("t1_data", 64'(write_data), 64'hDEADBEEF);
    idle(5'd0);

    // Load to x7 with hazard tracking
    cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 1'b0, 32'd0, 5'd7, 5'd0, 5'd0, 1'b0);
    idle(5'd7);
    cyc(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 32'h1234, 5'd7, 5'd0, 5'd0, 1'b0);
    idle(5'd7);
    idle(5'd7);
    check("t2_rdi", 64'(rdi), 64'd7);
    check("t2_data", 64'(write_data), 64'h1234);
    idle(5'd7);

    // Response contending with ALU writes
    cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 1'b0, 32'd0, 5'd0, 5'd0, 5'd0, 1'b0);
    cyc(1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 1'b1, 32'hABCD, 5'd9, 5'd0, 5'd0, 1'b0);
    for (int k = 0; k < 3; k++)
      cyc(1'b1, 5'd3, 32'h40 + 32'(k), 1'b0, 5'd0, 1'b0, 32'd0, 5'd9, 5'd0, 5'd0, 1'b0);
    idle(5'd9);
    check("t3_rdi", 64'(rdi), 64'd9);
    idle(5'd9);

    // Fill the queue, try a fifth issue, drain in order
    for (int k = 1; k <= 4; k++)
      cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'(k), 1'b0, 32'd0, 5'd0, 5'd0, 5'd0, 1'b0);
    check("t4_ready", 64'(ld_issue_ready), 64'd0);
    check("t4_pending", 64'(pending), 64'd4);
    cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 1'b0, 32'd0, 5'd5, 5'd0, 5'd0, 1'b0);
    for (int k = 0; k < 4; k++)
      cyc(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 32'hA0 + 32'(k), 5'(k + 1), 5'd0, 5'd0, 1'b0);
    for (int k = 0; k < 3; k++) idle(5'd4);

    // Load to x0 never writes nor raises hazard
    cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 1'b0, 32'd0, 5'd0, 5'd0, 5'd0, 1'b0);
    cyc(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 32'h5555, 5'd0, 5'd0, 5'd0, 1'b0);
    idle(5'd0);
    idle(5'd0);

    // Stray response, then reset with loads outstanding
    cyc(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 32'h77, 5'd0, 5'd0, 5'd0, 1'b0);
    idle(5'd0);
    cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd10, 1'b0, 32'd0, 5'd0, 5'd0, 5'd0, 1'b0);
    cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd11, 1'b0, 32'd0, 5'd10, 5'd0, 5'd0, 1'b0);
    cyc(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 32'd0, 5'd11, 5'd0, 5'd0, 1'b1);
    check("t6_pending", 64'(pending), 64'd0);
    check("t6_hazard", 64'(hazard), 64'd0);
    check("t6_err", 64'(resp_err), 64'd0);
    cyc(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 32'h99, 5'd0, 5'd0, 5'd0, 1'b0);
    cyc(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 32'd0, 5'd0, 5'd0, 5'd0, 1'b1);

    // Random traffic respecting the decode hazard contract
    for (int n = 0; n < 400; n++) begin
      a_v = ($urandom_range(0, 2) == 0);
      i_v = ($urandom_range(0, 1) == 1);
      rrd = 5'($urandom_range(0, 31));
      if (m_busy(rrd)) rrd = 5'd0;
      r_v = m_has_unfilled() && ($urandom_range(0, 1) == 1);
      cyc(a_v, 5'($urandom_range(0, 31)), $urandom, i_v, rrd, r_v, $urandom,
          5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
